// File: rtl/bank_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bank_rd_arbiter
//  Brief    : Read arbiter and return sequencer for the four-bank ECC memory.
//             Grants one requester per cycle, issues a one-hot bank read
//             enable, then delays {valid, bank, id} by READ_LATENCY so the
//             output MUX select and requester tag line up with bank data.
//  Options  : BANK_RR_ARB_EN - round-robin arbitration when defined,
//             fixed priority (lowest index wins) when undefined.
//  Revision : 1.0 - initial release
// ============================================================================
module bank_rd_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int ADDR_1       = 5,
    parameter int ADDR_2       = 4,
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [3:0]                    o_rd_en,
    output logic [ADDR_WIDTH-1:0]         o_rd_addr,
    output logic [1:0]                    o_sel,
    output logic                          o_rvalid,
    output logic [$clog2(NUM_REQ)-1:0]    o_rid,
    output logic                          o_idle
);

    localparam int C_IDW = $clog2(NUM_REQ);

    // Arbitration results for the current cycle
    logic [NUM_REQ-1:0]    w_gnt;
    logic [C_IDW-1:0]      w_gnt_id;
    logic                  w_gnt_vld;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [1:0]            w_bank;

    // Issue stage
    logic                  r_iss_v_q;
    logic [1:0]            r_iss_bank_q;
    logic [C_IDW-1:0]      r_iss_id_q;
    logic [3:0]            r_rd_en_q;
    logic [ADDR_WIDTH-1:0] r_rd_addr_q;

    // Return pipe; index READ_LATENCY-1 is the tail feeding the outputs
    logic [READ_LATENCY-1:0] r_pv_q;
    logic [1:0]              r_pbank_q [READ_LATENCY];
    logic [C_IDW-1:0]        r_pid_q   [READ_LATENCY];

`ifdef BANK_RR_ARB_EN
    logic [C_IDW-1:0] r_ptr_q;
    logic [C_IDW-1:0] r_ptr_d;
    int               w_dist;
    int               w_best_dist;

    // Round-robin pick: requester with the smallest distance from pointer+1
    always_comb begin
        w_gnt_id    = '0;
        w_gnt_vld   = 1'b0;
        w_dist      = 0;
        w_best_dist = NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req[k]) begin
                w_dist = (k + NUM_REQ - 1 - int'(r_ptr_q)) % NUM_REQ;
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_gnt_id    = C_IDW'(k);
                    w_gnt_vld   = 1'b1;
                end
            end
        end
        if (i_rst) begin
            w_gnt_vld = 1'b0;
        end
        r_ptr_d = w_gnt_vld ? w_gnt_id : r_ptr_q;
    end

    // Last-grant pointer; reset so that requester 0 is searched first
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr_q <= C_IDW'(NUM_REQ - 1);
        end else begin
            r_ptr_q <= r_ptr_d;
        end
    end
`else
    // Fixed priority pick: scan downwards so the lowest active index wins
    always_comb begin
        w_gnt_id  = '0;
        w_gnt_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_gnt_id  = C_IDW'(k);
                w_gnt_vld = 1'b1;
            end
        end
        if (i_rst) begin
            w_gnt_vld = 1'b0;
        end
    end
`endif

    // One-hot grant, granted address mux and bank field extraction
    always_comb begin
        w_gnt      = '0;
        w_gnt_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_gnt[k] = w_gnt_vld && (int'(w_gnt_id) == k);
            if (w_gnt[k]) begin
                w_gnt_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        w_bank = w_gnt_addr[ADDR_1-1:ADDR_2-1];
    end

    // Issue stage: read enable is a single-cycle strobe, address/tag hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iss_v_q    <= 1'b0;
            r_iss_bank_q <= 2'b00;
            r_iss_id_q   <= '0;
            r_rd_en_q    <= 4'b0000;
            r_rd_addr_q  <= '0;
        end else begin
            r_iss_v_q <= w_gnt_vld;
            r_rd_en_q <= w_gnt_vld ? (4'b0001 << w_bank) : 4'b0000;
            if (w_gnt_vld) begin
                r_iss_bank_q <= w_bank;
                r_iss_id_q   <= w_gnt_id;
                r_rd_addr_q  <= w_gnt_addr;
            end
        end
    end

    // Latency pipe: data only advances with a valid entry so the tail keeps
    // the last returned select/ID while idle (no MUX select glitches)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pbank_q[i] <= 2'b00;
                r_pid_q[i]   <= '0;
            end
        end else begin
            r_pv_q[0] <= r_iss_v_q;
            if (r_iss_v_q) begin
                r_pbank_q[0] <= r_iss_bank_q;
                r_pid_q[0]   <= r_iss_id_q;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv_q[i] <= r_pv_q[i-1];
                if (r_pv_q[i-1]) begin
                    r_pbank_q[i] <= r_pbank_q[i-1];
                    r_pid_q[i]   <= r_pid_q[i-1];
                end
            end
        end
    end

    assign o_gnt     = w_gnt;
    assign o_rd_en   = r_rd_en_q;
    assign o_rd_addr = r_rd_addr_q;
    assign o_rvalid  = r_pv_q[READ_LATENCY-1];
    assign o_sel     = r_pbank_q[READ_LATENCY-1];
    assign o_rid     = r_pid_q[READ_LATENCY-1];
    assign o_idle    = ~(r_iss_v_q | (|r_pv_q));

endmodule
`default_nettype wire

// File: doc/bank_rd_arbiter.md
# bank_rd_arbiter

Read-access arbiter and return sequencer for the four-bank ECC memory. It shares the banked read path between NUM_REQ requesters and issues a one-hot bank read enable for the selected request. It then delays the bank select by the bank read latency so the 4:1 output multiplexer routes the correct encoded word. The returned word is tagged with the ID of the requester that issued it. The block sits between the requester ports and the bank array / output MUX.

## Interface
Parameters:
- ADDR_WIDTH, 5, width of each requester read address.
- ADDR_1, 5, bank field upper bound; the bank index is address bits [ADDR_1-1:ADDR_2-1].
- ADDR_2, 4, bank field lower bound; ADDR_1-ADDR_2 must equal 1, giving a 2-bit bank field.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- READ_LATENCY, 2, cycles from o_rd_en to bank data valid; legal range 1..8.

Ports:
- i_clk  in  1  single clock; every register updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  NUM_REQ  per-requester read request level.
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_gnt  out  NUM_REQ  one-hot grant for the current cycle (combinational).
- o_rd_en  out  4  one-hot bank read enable (registered).
- o_rd_addr  out  ADDR_WIDTH  address of the issued read (registered).
- o_sel  out  2  select to the output MUX, aligned to bank data.
- o_rvalid  out  1  output-channel data valid for the current cycle.
- o_rid  out  $clog2(NUM_REQ)  requester ID of the returning word.
- o_idle  out  1  high when no read is outstanding in the issue stage or the latency pipe.

## Operation
- Request handshake:
  - A requester holds i_req high with a stable i_addr until it sees o_gnt[k] high.
  - The request is accepted at the clock edge at which o_gnt[k] is high.
  - The requester may then drop i_req or present a new address in the next cycle.
- At most one grant per cycle. The arbiter never grants a requester whose i_req is low. If i_req is all-zero, o_gnt = 0.
- Arbitration is round-robin (see Configuration):
  - A last-grant pointer is updated only in cycles with a grant.
  - The search starts at pointer+1 and wraps modulo NUM_REQ.
  - The reset value of the pointer is NUM_REQ-1, so requester 0 wins first.
- Issue stage (registered on the grant edge):
  - o_rd_en = one-hot of the granted address bits [ADDR_1-1:ADDR_2-1].
  - o_rd_addr = granted address.
  - An internal ID register captures the granted requester index.
- Return pipe:
  - A READ_LATENCY-deep shift register carries {valid, bank, id} from the issue stage.
  - Its tail drives o_rvalid, o_sel and o_rid.
  - It accepts one entry per cycle and has no backpressure.
- Back-to-back grants to the same bank or to different banks are both legal; each issues in consecutive cycles.
- While o_rvalid is low, o_sel holds its last value (MUX glitch avoidance). o_rid also holds its last value.
- o_idle = ~(issue valid | any pipe valid). It is registered-derived and glitch-free.

## Timing
- Reset values: o_rd_en=0, o_rd_addr=0, o_sel=0, o_rvalid=0, o_rid=0, o_idle=1, pointer=NUM_REQ-1, all pipe valids cleared.
- o_gnt is also forced to 0 during any cycle in which i_rst is high.
- Grant in cycle T:
  - T+1: o_rd_en and o_rd_addr are valid for exactly one cycle.
  - T+1+READ_LATENCY: o_rvalid, o_sel and o_rid are valid for one cycle.
- Throughput is one read per cycle sustained.
- Reset asserted mid-operation discards all outstanding reads. No o_rvalid is produced for them after reset, including in the first cycle after reset deasserts.
- Simultaneous request from the current pointer+1 holder and from others: pointer+1 wins.
- A requester dropping i_req in the same cycle it would be granted is not granted.

## Configuration
- BANK_RR_ARB_EN defined: round-robin arbitration as described above.
- BANK_RR_ARB_EN undefined:
  - Fixed priority: the lowest requester index with i_req high wins.
  - The pointer register is not implemented.
  - All other behaviour and timing are identical.

## Test plan
- Reset with i_req=4'b1111 held high -> o_gnt=0, o_rvalid=0, o_idle=1 throughout reset. The first grant after release is 4'b0001.
- Single request: requester 2 with addr 5'b01000 (bank 1) granted at T -> o_rd_en=4'b0010 at T+1; at T+3 (READ_LATENCY=2), o_rvalid=1, o_sel=2'b01, o_rid=2.
- All four requesters held high for 8 cycles -> grants go 0,1,2,3,0,1,2,3 with BANK_RR_ARB_EN defined; without it, all 8 grants go to requester 0.
- Back-to-back reads to banks 3,0,2 on consecutive cycles -> o_sel=3,0,2 on three consecutive o_rvalid cycles, with matching o_rid values.
- Reset asserted one cycle after issue with a read outstanding -> no o_rvalid is ever seen for that read; o_idle=1 after reset.
- i_req pulses for requester 1 only, every third cycle -> exactly one grant per pulse; o_idle goes low from T+1 through T+1+READ_LATENCY and returns high afterwards.
